icache_bk_ctrl: RTL and testbench
=================================

# icache_bk_ctrl

Control FSM for the direct-mapped backup instruction-cache datapath. It sequences the cache's hit check, the line refill from physical memory, and the tag/valid/data array writes. It also performs the CPU-side and memory-side request/response handshakes. It sits between the fetch stage, the cache datapath and the physical-memory arbiter port, and optionally keeps hit/miss performance counters.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter; exists only when the performance-counter feature is compiled in.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_read  in  1  CPU fetch request; held high, with a stable address, until mem_resp.
- mem_resp  out  1  CPU response; the requested line is valid on the datapath output this cycle.
- is_hit  in  1  datapath tag match AND valid, combinational for the current address.
- pmem_read  out  1  refill request to physical memory.
- pmem_resp  in  1  one-cycle pulse; pmem_rdata is valid in the same cycle.
- load_data  out  1  data-array write enable.
- load_tag  out  1  tag-array write enable.
- load_valid  out  1  valid-array write enable.
- valid_in  out  1  value written into the valid array.
- hit_count  out  CNT_W  saturating count of first-try hits; present only with the feature compiled in.
- miss_count  out  CNT_W  saturating count of refills started; present only with the feature compiled in.

## Operation
- States: CHECK, FILL, RECHECK.
- CHECK:
  - With mem_read=0, all outputs are 0 and the state stays CHECK.
  - With mem_read=1 and is_hit=1, drive mem_resp=1 combinationally and stay in CHECK.
  - With mem_read=1 and is_hit=0, go to FILL.
- FILL:
  - Hold pmem_read=1.
  - In the cycle pmem_resp=1, drive load_data=load_tag=load_valid=1 and valid_in=1, then go to RECHECK.
  - The state does not advance while pmem_resp=0; there is no timeout.
- RECHECK:
  - With mem_read=1 and is_hit=1, drive mem_resp=1 and return to CHECK.
  - With mem_read=1 and is_hit=0, go back to FILL.
  - With mem_read=0, return to CHECK and do not respond.
- Refill abort: if mem_read drops during FILL, the transaction still completes and the line is written, because the physical-memory port cannot abort.
- valid_in is 1 whenever load_valid=1; the controller never writes a 0 into the valid array.
- mem_resp is asserted for exactly one cycle per completed request only when mem_read stays high. If mem_read is still high the following cycle, that cycle is a new request.
- An illegal state encoding goes to CHECK with all outputs 0.

## Timing
- Reset: state=CHECK. mem_resp, pmem_read, load_data, load_tag, load_valid, valid_in all read 0, and the counters are 0.
- Hit latency: 0 cycles. mem_resp is asserted in the same cycle that mem_read is seen with is_hit=1.
- Miss latency: 1 + N + 1 cycles from mem_read, where N is the number of cycles from the first pmem_read to pmem_resp:
  - 1 cycle of CHECK;
  - N cycles of FILL, with the array writes on the pmem_resp edge;
  - 1 cycle of RECHECK carrying mem_resp.
- pmem_read rises on the cycle after the miss is detected, because it is decoded from the FILL state.
- pmem_read falls in the cycle after pmem_resp.
- Reset mid-FILL: the state returns to CHECK immediately and pmem_read drops. Any late pmem_resp is ignored.
- Simultaneous mem_read rise and reset release: the request is evaluated on the first clock edge after rst goes high.

## Configuration
- ICACHE_BK_PERF_EN defined:
  - hit_count increments on every mem_resp issued from CHECK.
  - miss_count increments on every CHECK→FILL and RECHECK→FILL transition.
  - Both counters saturate at all-ones and are cleared only by reset.
- ICACHE_BK_PERF_EN undefined: the counter registers, the hit_count/miss_count ports and the CNT_W parameter are all absent. FSM behaviour is identical in both builds.

## Structure
- The package rv32i_types holds:
  - icache_ctrl_state_t, an enum of CHECK, FILL and RECHECK;
  - the localparam default for CNT_W.
- There is one sub-module, icache_bk_sat_counter, a CNT_W-bit saturating counter with inc and asynchronous active-low reset. It is instantiated twice, and only under ICACHE_BK_PERF_EN.
- Outputs are decoded combinationally from the state plus the inputs; only the state and the counters are registered.

## Test plan
- Reset, then idle for 5 cycles with mem_read=0 → all outputs 0, state CHECK, counters 0.
- Hit: mem_read=1 and is_hit=1 in the same cycle → mem_resp=1 that cycle, pmem_read never asserted, hit_count=1.
- Miss with N=4: mem_read=1 and is_hit=0 →
  - pmem_read high for 4 cycles;
  - load_data/load_tag/load_valid/valid_in=1 on the pmem_resp cycle;
  - is_hit forced to 1, then mem_resp on the next cycle;
  - miss_count=1 and hit_count=0.
- mem_read dropped during FILL → the fill completes with the array writes, no mem_resp is issued, and the FSM is in CHECK 2 cycles after pmem_resp.
- rst asserted in the second cycle of FILL → pmem_read=0 immediately, a pmem_resp delivered 1 cycle later produces no load_*, and the state is CHECK.
- With CNT_W=4, drive 20 back-to-back hits → hit_count stops at 15; with ICACHE_BK_PERF_EN undefined the build elaborates without the counter ports.

Source files
------------

// File: rtl/icache_bk_ctrl_pkg.sv
// ============================================================================
// Module      : rv32i_types (package)
// Description : Shared types for the backup instruction-cache controller:
//               the controller state enumeration and counter width default.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

    // Default width of the optional hit/miss performance counters
    localparam int CNT_W_DEFAULT = 32;

    // Controller states; encoding 2'b11 is illegal and recovers to CHECK
    typedef enum logic [1:0] {
        CHECK   = 2'b00,
        FILL    = 2'b01,
        RECHECK = 2'b10
    } icache_ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/icache_bk_sat_counter.sv
// ============================================================================
// Module      : icache_bk_sat_counter
// Description : CNT_W-bit up-counter that sticks at all-ones. Cleared only by
//               the asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_bk_sat_counter
    import rv32i_types::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Count up on inc, holding once every bit is set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + C_ONE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/icache_bk_ctrl.sv
// ============================================================================
// Module      : icache_bk_ctrl
// Description : Control FSM for the direct-mapped backup instruction cache.
//               Checks for a hit, refills a missing line from physical
//               memory, writes tag/valid/data arrays and answers the CPU.
//               Optional hit/miss counters are built when the macro
//               ICACHE_BK_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_bk_ctrl
    import rv32i_types::*;
`ifdef ICACHE_BK_PERF_EN
#(
    parameter int CNT_W = CNT_W_DEFAULT
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    output logic             mem_resp,
    input  logic             is_hit,
    output logic             pmem_read,
    input  logic             pmem_resp,
    output logic             load_data,
    output logic             load_tag,
    output logic             load_valid,
    output logic             valid_in
`ifdef ICACHE_BK_PERF_EN
    ,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
`endif
);

    icache_ctrl_state_t state;
    icache_ctrl_state_t state_next;

    // State register; reset drops an in-flight refill immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CHECK;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode; outputs depend on state plus inputs
    always_comb begin
        state_next = state;
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        load_data  = 1'b0;
        load_tag   = 1'b0;
        load_valid = 1'b0;
        valid_in   = 1'b0;
        case (state)
            CHECK: begin
                if (mem_read) begin
                    if (is_hit) begin
                        mem_resp = 1'b1;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                // The memory port cannot abort, so mem_read is ignored here
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    load_data  = 1'b1;
                    load_tag   = 1'b1;
                    load_valid = 1'b1;
                    valid_in   = 1'b1;
                    state_next = RECHECK;
                end
            end
            RECHECK: begin
                if (mem_read) begin
                    if (is_hit) begin
                        mem_resp   = 1'b1;
                        state_next = CHECK;
                    end else begin
                        state_next = FILL;
                    end
                end else begin
                    state_next = CHECK;
                end
            end
            default: begin
                state_next = CHECK;
            end
        endcase
    end

`ifdef ICACHE_BK_PERF_EN
    logic hit_inc;
    logic miss_inc;

    // First-try hits answer from CHECK; every entry into FILL is a refill
    always_comb begin
        hit_inc  = mem_resp && (state == CHECK);
        miss_inc = (state_next == FILL) && (state != FILL);
    end

    icache_bk_sat_counter #(
        .CNT_W (CNT_W)
    ) u_hit_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .count (hit_count)
    );

    icache_bk_sat_counter #(
        .CNT_W (CNT_W)
    ) u_miss_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .count (miss_count)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_bk_ctrl.sv
// ============================================================================
// Module      : tb_icache_bk_ctrl
// Description : Self-checking bench for icache_bk_ctrl: a per-cycle vector
//               table for hit/miss/abort flows plus directed reset and
//               saturation sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_bk_ctrl;

    logic clk;
    logic rst;
    logic mem_read;
    logic is_hit;
    logic pmem_resp;
    logic mem_resp;
    logic pmem_read;
    logic load_data;
    logic load_tag;
    logic load_valid;
    logic valid_in;

    int tests_run;
    int tests_failed;

    localparam logic [1:0] S_C = 2'b00;
    localparam logic [1:0] S_F = 2'b01;
    localparam logic [1:0] S_R = 2'b10;

`ifdef ICACHE_BK_PERF_EN
    logic [3:0] hit_count;
    logic [3:0] miss_count;

    icache_bk_ctrl #(
        .CNT_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_resp   (mem_resp),
        .is_hit     (is_hit),
        .pmem_read  (pmem_read),
        .pmem_resp  (pmem_resp),
        .load_data  (load_data),
        .load_tag   (load_tag),
        .load_valid (load_valid),
        .valid_in   (valid_in),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );
`else
    icache_bk_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_resp   (mem_resp),
        .is_hit     (is_hit),
        .pmem_read  (pmem_read),
        .pmem_resp  (pmem_resp),
        .load_data  (load_data),
        .load_tag   (load_tag),
        .load_valid (load_valid),
        .valid_in   (valid_in)
    );
`endif

    // Output bundle {mem_resp, pmem_read, load_data, load_tag, load_valid, valid_in}
    logic [5:0] outs;
    logic [1:0] st;
    always_comb begin
        outs = {mem_resp, pmem_read, load_data, load_tag, load_valid, valid_in};
        st   = dut.state;
    end

    typedef struct packed {
        logic       mem_read;
        logic       is_hit;
        logic       pmem_resp;
        logic [5:0] exp_out;
        logic [1:0] exp_state;
    } vec_t;

    vec_t vecs[$];

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic mr, input logic hit, input logic pr,
                       input logic [5:0] eo, input logic [1:0] es);
        vec_t v;
        v.mem_read  = mr;
        v.is_hit    = hit;
        v.pmem_resp = pr;
        v.exp_out   = eo;
        v.exp_state = es;
        vecs.push_back(v);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b0;
        mem_read  = 1'b0;
        is_hit    = 1'b0;
        pmem_resp = 1'b0;

        // Per-cycle vectors: inputs applied, combinational outputs and current state expected
        for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 1'b0, 6'b000000, S_C); // idle
        add(1'b1, 1'b1, 1'b0, 6'b100000, S_C); // hit, zero latency
        add(1'b0, 1'b0, 1'b0, 6'b000000, S_C);
        add(1'b1, 1'b0, 1'b0, 6'b000000, S_C); // miss detected
        add(1'b1, 1'b0, 1'b0, 6'b010000, S_F); // N=4 refill
        add(1'b1, 1'b0, 1'b0, 6'b010000, S_F);
        add(1'b1, 1'b0, 1'b0, 6'b010000, S_F);
        add(1'b1, 1'b0, 1'b1, 6'b011111, S_F); // array writes
        add(1'b1, 1'b1, 1'b0, 6'b100000, S_R); // response after refill
        add(1'b0, 1'b0, 1'b0, 6'b000000, S_C);
        add(1'b1, 1'b0, 1'b0, 6'b000000, S_C); // miss, then request dropped
        add(1'b0, 1'b0, 1'b0, 6'b010000, S_F);
        add(1'b0, 1'b0, 1'b1, 6'b011111, S_F); // fill still completes
        add(1'b0, 1'b0, 1'b0, 6'b000000, S_R); // no response
        add(1'b1, 1'b1, 1'b0, 6'b100000, S_C); // back in CHECK
        add(1'b1, 1'b0, 1'b0, 6'b000000, S_C); // miss
        add(1'b1, 1'b0, 1'b1, 6'b011111, S_F); // N=1
        add(1'b1, 1'b0, 1'b0, 6'b000000, S_R); // still missing -> refill again
        add(1'b1, 1'b0, 1'b1, 6'b011111, S_F);
        add(1'b1, 1'b1, 1'b0, 6'b100000, S_R);
        add(1'b0, 1'b0, 1'b0, 6'b000000, S_C);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_outputs", {26'd0, outs}, 32'd0);
        check("reset_state", {30'd0, st}, {30'd0, S_C});
`ifdef ICACHE_BK_PERF_EN
        check("reset_counters", {24'd0, hit_count, miss_count}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // Table-driven flow
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            mem_read  = vecs[i].mem_read;
            is_hit    = vecs[i].is_hit;
            pmem_resp = vecs[i].pmem_resp;
            #1;
            check($sformatf("vec%0d", i), {24'd0, outs, st},
                  {24'd0, vecs[i].exp_out, vecs[i].exp_state});
        end
`ifdef ICACHE_BK_PERF_EN
        #1;
        check("hit_count_after_table", {28'd0, hit_count}, 32'd2);
        check("miss_count_after_table", {28'd0, miss_count}, 32'd4);
`endif

        // Reset asserted in the second FILL cycle
        @(negedge clk);
        mem_read = 1'b1; is_hit = 1'b0; pmem_resp = 1'b0;
        #1;
        check("rmf_miss_check", {30'd0, st}, {30'd0, S_C});
        @(negedge clk);
        #1;
        check("rmf_fill1", {31'd0, pmem_read}, 32'd1);
        @(negedge clk);
        #1;
        check("rmf_fill2", {31'd0, pmem_read}, 32'd1);
        #1;
        rst = 1'b0;
        mem_read = 1'b0;
        #1;
        check("rmf_reset_now", {24'd0, outs, st}, {24'd0, 6'b000000, S_C});
        @(negedge clk);
        rst = 1'b1;
        pmem_resp = 1'b1;
        #1;
        check("rmf_late_resp", {24'd0, outs, st}, {24'd0, 6'b000000, S_C});
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        check("rmf_state_after", {30'd0, st}, {30'd0, S_C});

        // Fresh reset, then 20 back-to-back hits
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mem_read = 1'b1; is_hit = 1'b1;
            #1;
            check($sformatf("hit_burst%0d", i), {24'd0, outs, st},
                  {24'd0, 6'b100000, S_C});
        end
        @(negedge clk);
        mem_read = 1'b0; is_hit = 1'b0;
        #1;
        check("after_burst_idle", {24'd0, outs, st}, {24'd0, 6'b000000, S_C});
`ifdef ICACHE_BK_PERF_EN
        check("hit_count_saturated", {28'd0, hit_count}, 32'd15);
        check("miss_count_zero", {28'd0, miss_count}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
